// File: rtl/rsa_mode_controller.sv
// Top-level sequencer for the lab2 RSA datapath: key-length selection, core launch,
// finish/timeout/abort handling and display-facing state/width buses.
module rsa_mode_controller #(
    parameter int unsigned TIMEOUT = 100_000_000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_mode,
    input  logic             i_key_start,
    input  logic             i_key_abort,
    input  logic             i_rsa_finished,
    output logic [9:0]       o_rsa_bit,
    output logic [1:0]       o_rsa_mode,
    output logic [1:0]       o_state,
    output logic             o_rsa_start,
    output logic             o_rsa_abort,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        CALC  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Counter value seen on the last CALC edge before a forced completion.
    localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] mode_next;
    logic [9:0] bit_next;

    // 128 -> 256 -> 512 -> 128; encoding 3 is never produced.
    assign mode_next = (o_rsa_mode == 2'd2) ? 2'd0 : o_rsa_mode + 2'd1;

    always_comb begin
        bit_next = 10'b00_1000_0000;
        case (mode_next)
            2'd1:    bit_next = 10'b01_0000_0000;
            2'd2:    bit_next = 10'b10_0000_0000;
            default: bit_next = 10'b00_1000_0000;
        endcase
    end

    // The state register doubles as the display state bus.
    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_rsa_bit   <= 10'b00_1000_0000;
            o_rsa_mode  <= 2'd0;
            o_rsa_start <= 1'b0;
            o_rsa_abort <= 1'b0;
            o_timeout   <= 1'b0;
            o_cycles    <= '0;
        end else begin
            o_rsa_start <= 1'b0;
            o_rsa_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_key_start) begin
                        state       <= START;
                        o_rsa_start <= 1'b1;
                        o_cycles    <= '0;
                        o_timeout   <= 1'b0;
                    end else if (i_key_mode) begin
                        o_rsa_mode <= mode_next;
                        o_rsa_bit  <= bit_next;
                    end
                end
                START: begin
                    if (i_key_abort) begin
                        state       <= IDLE;
                        o_rsa_abort <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Exit priority: abort, then finish, then timeout.
                    if (i_key_abort) begin
                        state       <= IDLE;
                        o_rsa_abort <= 1'b1;
                    end else if (i_rsa_finished) begin
                        state     <= DONE;
                        o_timeout <= 1'b0;
                    end else if (o_cycles == CYCLE_LAST) begin
                        state     <= DONE;
                        o_timeout <= 1'b1;
                    end else if (o_cycles != {CNT_W{1'b1}}) begin
                        o_cycles <= o_cycles + 1'b1;
                    end
                end
                DONE: begin
                    if (i_key_start || i_key_mode) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mode_controller.sv
// Directed bench for rsa_mode_controller with a short timeout (16 CALC cycles).
module tb_rsa_mode_controller;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 16;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_key_mode;
    logic             i_key_start;
    logic             i_key_abort;
    logic             i_rsa_finished;
    logic [9:0]       o_rsa_bit;
    logic [1:0]       o_rsa_mode;
    logic [1:0]       o_state;
    logic             o_rsa_start;
    logic             o_rsa_abort;
    logic             o_timeout;
    logic [CNT_W-1:0] o_cycles;

    int pass_cnt;
    int total_cnt;

    rsa_mode_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_key_mode     (i_key_mode),
        .i_key_start    (i_key_start),
        .i_key_abort    (i_key_abort),
        .i_rsa_finished (i_rsa_finished),
        .o_rsa_bit      (o_rsa_bit),
        .o_rsa_mode     (o_rsa_mode),
        .o_state        (o_state),
        .o_rsa_start    (o_rsa_start),
        .o_rsa_abort    (o_rsa_abort),
        .o_timeout      (o_timeout),
        .o_cycles       (o_cycles)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs are changed and outputs sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic press_start();
        i_key_start = 1'b1;
        step();
        i_key_start = 1'b0;
    endtask

    task automatic press_mode();
        i_key_mode = 1'b1;
        step();
        i_key_mode = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1; i_key_mode = 0; i_key_start = 0; i_key_abort = 0; i_rsa_finished = 0;
        #2 i_rst_n = 1'b0;
        step(); step();
        total_cnt++;
        if (o_rsa_bit !== 10'h080) $display("FAIL reset_bit: got %h want 080", o_rsa_bit); else pass_cnt++;
        total_cnt++;
        if (o_rsa_mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", o_rsa_mode); else pass_cnt++;
        total_cnt++;
        if (o_state !== 2'b00) $display("FAIL reset_state: got %b want 00", o_state); else pass_cnt++;
        total_cnt++;
        if ({o_rsa_start, o_rsa_abort, o_timeout} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {o_rsa_start, o_rsa_abort, o_timeout}); else pass_cnt++;
        total_cnt++;
        if (o_cycles !== '0) $display("FAIL reset_cycles: got %0d want 0", o_cycles); else pass_cnt++;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode_cycle();
        logic [9:0] exp_bit[3];
        logic [1:0] exp_mode[3];
        exp_bit  = '{10'h100, 10'h200, 10'h080};
        exp_mode = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            press_mode();
            total_cnt++;
            if (o_rsa_bit !== exp_bit[i])
                $display("FAIL mode_bit[%0d]: got %h want %h", i, o_rsa_bit, exp_bit[i]); else pass_cnt++;
            total_cnt++;
            if (o_rsa_mode !== exp_mode[i])
                $display("FAIL mode_enc[%0d]: got %0d want %0d", i, o_rsa_mode, exp_mode[i]); else pass_cnt++;
        end
        total_cnt++;
        if (o_state !== 2'b00) $display("FAIL mode_state: got %b want 00", o_state); else pass_cnt++;
    endtask

    task automatic test_finish();
        press_mode();
        press_start();
        total_cnt++;
        if (o_state !== 2'b01 || o_rsa_start !== 1'b1)
            $display("FAIL fin_start: state %b start %b want 01/1", o_state, o_rsa_start); else pass_cnt++;
        step();
        total_cnt++;
        if (o_state !== 2'b10 || o_rsa_start !== 1'b0)
            $display("FAIL fin_calc: state %b start %b want 10/0", o_state, o_rsa_start); else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            i_key_mode = (i == 2);
            step();
            total_cnt++;
            if (o_state !== 2'b10 || o_cycles !== CNT_W'(i) || o_rsa_bit !== 10'h100)
                $display("FAIL fin_run[%0d]: state %b cycles %0d bit %h want 10/%0d/100",
                         i, o_state, o_cycles, o_rsa_bit, i); else pass_cnt++;
        end
        i_key_mode = 1'b0;
        i_rsa_finished = 1'b1;
        step();
        i_rsa_finished = 1'b0;
        total_cnt++;
        if (o_state !== 2'b11 || o_cycles !== 32'd5 || o_timeout !== 1'b0 || o_rsa_bit !== 10'h100)
            $display("FAIL fin_done: state %b cycles %0d to %b bit %h want 11/5/0/100",
                     o_state, o_cycles, o_timeout, o_rsa_bit); else pass_cnt++;
        i_key_abort = 1'b1;
        step();
        i_key_abort = 1'b0;
        total_cnt++;
        if (o_state !== 2'b11 || o_rsa_abort !== 1'b0 || o_cycles !== 32'd5)
            $display("FAIL done_abort_ignored: state %b abort %b cycles %0d want 11/0/5",
                     o_state, o_rsa_abort, o_cycles); else pass_cnt++;
        press_mode();
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_bit !== 10'h100 || o_rsa_mode !== 2'd1)
            $display("FAIL done_mode_exit: state %b bit %h mode %0d want 00/100/1",
                     o_state, o_rsa_bit, o_rsa_mode); else pass_cnt++;
    endtask

    task automatic test_timeout();
        press_start();
        step();
        for (int i = 1; i < int'(TIMEOUT); i++) step();
        total_cnt++;
        if (o_state !== 2'b10 || o_cycles !== 32'd15)
            $display("FAIL to_pre: state %b cycles %0d want 10/15", o_state, o_cycles); else pass_cnt++;
        step();
        total_cnt++;
        if (o_state !== 2'b11 || o_timeout !== 1'b1 || o_cycles !== 32'd15)
            $display("FAIL to_done: state %b to %b cycles %0d want 11/1/15",
                     o_state, o_timeout, o_cycles); else pass_cnt++;
        press_start();
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_start !== 1'b0)
            $display("FAIL to_ack: state %b start %b want 00/0", o_state, o_rsa_start); else pass_cnt++;
        press_start();
        total_cnt++;
        if (o_timeout !== 1'b0 || o_cycles !== '0)
            $display("FAIL to_clear: to %b cycles %0d want 0/0", o_timeout, o_cycles); else pass_cnt++;
        step();
        for (int i = 1; i < int'(TIMEOUT); i++) step();
        i_rsa_finished = 1'b1;
        step();
        i_rsa_finished = 1'b0;
        total_cnt++;
        if (o_state !== 2'b11 || o_timeout !== 1'b0 || o_cycles !== 32'd15)
            $display("FAIL to_fin_tie: state %b to %b cycles %0d want 11/0/15",
                     o_state, o_timeout, o_cycles); else pass_cnt++;
        press_mode();
    endtask

    task automatic test_abort();
        press_start();
        step();
        step(); step(); step();
        i_key_abort = 1'b1;
        step();
        i_key_abort = 1'b0;
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_abort !== 1'b1 || o_rsa_start !== 1'b0)
            $display("FAIL abort_calc: state %b abort %b start %b want 00/1/0",
                     o_state, o_rsa_abort, o_rsa_start); else pass_cnt++;
        step();
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_abort !== 1'b0)
            $display("FAIL abort_width: state %b abort %b want 00/0", o_state, o_rsa_abort); else pass_cnt++;
        press_start();
        step();
        step(); step();
        i_key_abort = 1'b1; i_rsa_finished = 1'b1;
        step();
        i_key_abort = 1'b0; i_rsa_finished = 1'b0;
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_abort !== 1'b1)
            $display("FAIL abort_vs_fin: state %b abort %b want 00/1", o_state, o_rsa_abort); else pass_cnt++;
        i_rsa_finished = 1'b1; i_key_abort = 1'b1;
        step();
        i_rsa_finished = 1'b0; i_key_abort = 1'b0;
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_abort !== 1'b0)
            $display("FAIL idle_ignore: state %b abort %b want 00/0", o_state, o_rsa_abort); else pass_cnt++;
        press_start();
        i_key_abort = 1'b1;
        step();
        i_key_abort = 1'b0;
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_abort !== 1'b1 || o_rsa_start !== 1'b0)
            $display("FAIL abort_start: state %b abort %b start %b want 00/1/0",
                     o_state, o_rsa_abort, o_rsa_start); else pass_cnt++;
        step();
    endtask

    task automatic test_simultaneous();
        i_key_mode = 1'b1; i_key_start = 1'b1;
        step();
        i_key_mode = 1'b0; i_key_start = 1'b0;
        total_cnt++;
        if (o_state !== 2'b01 || o_rsa_mode !== 2'd1 || o_rsa_bit !== 10'h100)
            $display("FAIL mode_start_tie: state %b mode %0d bit %h want 01/1/100",
                     o_state, o_rsa_mode, o_rsa_bit); else pass_cnt++;
        step();
        i_key_abort = 1'b1;
        step();
        i_key_abort = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        press_start();
        step(); step(); step(); step();
        #2 i_rst_n = 1'b0;
        #1;
        total_cnt++;
        if (o_state !== 2'b00 || o_rsa_bit !== 10'h080 || o_rsa_mode !== 2'd0 || o_cycles !== '0 ||
            {o_rsa_start, o_rsa_abort, o_timeout} !== 3'b000)
            $display("FAIL async_reset: state %b bit %h mode %0d cycles %0d flags %b want 00/080/0/0/000",
                     o_state, o_rsa_bit, o_rsa_mode, o_cycles,
                     {o_rsa_start, o_rsa_abort, o_timeout}); else pass_cnt++;
        step();
        i_rst_n = 1'b1;
        press_start();
        total_cnt++;
        if (o_state !== 2'b01 || o_rsa_start !== 1'b1)
            $display("FAIL post_rst_start: state %b start %b want 01/1", o_state, o_rsa_start); else pass_cnt++;
        step();
        i_rsa_finished = 1'b1;
        step();
        i_rsa_finished = 1'b0;
        total_cnt++;
        if (o_state !== 2'b11 || o_cycles !== '0 || o_timeout !== 1'b0)
            $display("FAIL post_rst_fin: state %b cycles %0d to %b want 11/0/0",
                     o_state, o_cycles, o_timeout); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_mode_cycle();
        test_finish();
        test_timeout();
        test_abort();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rsa_mode_controller.md
# rsa_mode_controller

Top-level sequencer for the lab2 RSA datapath. Selects the key length (128/256/512 bits) from a debounced mode key and launches the RSA core on a start key. It waits for the core's finish or a timeout, and supports a user abort. It drives the one-hot bit-width and 2-bit state buses consumed by the seven-segment display decoder, plus the start/abort strobes to the RSA core.

## Interface
- TIMEOUT, 100_000_000: maximum CALC cycles before forced completion (2 s at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 32: width of the cycle counter and o_cycles.
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_key_mode  in  1  one-cycle pulse (debounced), advance key length.
- i_key_start  in  1  one-cycle pulse (debounced), start operation / acknowledge result.
- i_key_abort  in  1  one-cycle pulse (debounced), abort running operation.
- i_rsa_finished  in  1  core completion, level or pulse; sampled only in CALC.
- o_rsa_bit  out  10  one-hot key length: bit7=128, bit8=256, bit9=512.
- o_rsa_mode  out  2  encoded key length to core: 0=128, 1=256, 2=512 (3 never driven).
- o_state  out  2  IDLE=00, START=01, CALC=10, DONE=11.
- o_rsa_start  out  1  one-cycle start strobe to core.
- o_rsa_abort  out  1  one-cycle abort strobe to core.
- o_timeout  out  1  last operation ended by timeout; valid in DONE.
- o_cycles  out  CNT_W  CALC cycle count of current/last operation.

## Operation
- All outputs registered. Reset values: o_rsa_bit=10'b0010000000, o_rsa_mode=0, o_state=00, o_rsa_start=0, o_rsa_abort=0, o_timeout=0, o_cycles=0.
- IDLE: i_key_start -> START. Otherwise i_key_mode advances 128->256->512->128. If both occur in the same cycle, start wins and the mode is unchanged.
- START: lasts exactly one cycle with o_rsa_start=1. o_cycles cleared to 0 and o_timeout cleared on entry. Next state is CALC unless i_key_abort.
- CALC: o_cycles increments by 1 each cycle (saturates at all ones). Exit priority is abort > finished > timeout:
  - i_key_abort -> IDLE; o_rsa_abort=1 for one cycle.
  - i_rsa_finished=1 -> DONE; o_timeout=0.
  - o_cycles==TIMEOUT-1 with no finish -> DONE; o_timeout=1.
- DONE: holds o_cycles and o_timeout. i_key_start or i_key_mode -> IDLE. The key causing the exit does not change mode or start a new operation. i_key_abort is ignored.
- Key length is frozen outside IDLE. o_rsa_bit and o_rsa_mode are always consistent and change only on an IDLE mode press.
- i_rsa_finished is ignored in IDLE, START and DONE. i_key_abort is ignored in IDLE and DONE.
- Abort in START: -> IDLE with o_rsa_abort=1. o_rsa_start has already pulsed that cycle.

## Timing
- Key pulse sampled at edge N is reflected in the outputs after edge N (one-cycle latency).
- Start sequence: start pulse at edge N gives START after N. o_rsa_start is high for cycle N..N+1 and CALC begins after N+1.
- Finish sampled at edge M in CALC gives o_state=11 after M. o_cycles equals the number of CALC edges before M, so a finish at the first CALC edge gives o_cycles=0.
- Timeout: DONE after exactly TIMEOUT edges in CALC, with o_cycles=TIMEOUT-1.
- Strobes o_rsa_start/o_rsa_abort are never high simultaneously and never longer than one cycle.
- Async reset mid-operation: all outputs return to reset values immediately, with no strobe. The first edge after deassertion is treated as IDLE.

## Test plan
- Reset, then 3 mode pulses. Expect o_rsa_bit 0x080 -> 0x100 -> 0x200 -> 0x080 and o_rsa_mode 0 -> 1 -> 2 -> 0, one cycle after each pulse.
- Mode=256, start, finish after 5 CALC cycles. Expect o_state 01 for 1 cycle with o_rsa_start=1, then 10, then 11. Expect o_cycles=5, o_timeout=0 and o_rsa_bit=0x100 throughout.
- TIMEOUT=16, start, no finish. Expect DONE after 16 CALC cycles with o_timeout=1 and o_cycles=15. Finish and timeout in the same cycle -> o_timeout=0.
- Abort at CALC cycle 3, and separately abort+finish in the same cycle. Expect IDLE with a 1-cycle o_rsa_abort and no DONE. Finish while in IDLE is ignored.
- Simultaneous mode+start in IDLE gives START with mode unchanged. Mode pulses during CALC/DONE leave o_rsa_bit unchanged. A mode pulse in DONE returns to IDLE without advancing the mode.
- Assert i_rst_n=0 mid-CALC. Expect all outputs at reset values without waiting for a clock. After release, a new start sequences normally.
